id_fwd_ctrl: RTL and testbench

Parametrised decode-stage front end for the 5-stage MIPS pipeline. It sits between IF and the decoder/regfile. It owns the IF/ID pipeline register and an instruction hold buffer for stalls under synchronous instruction SRAM. It forwards from N in-flight write sources with fixed priority and raises a load-use interlock that is qualified by operand use. It also keeps a saturating stall-cycle counter.

---
 rtl/id_fwd_ctrl_pkg.sv | 22 ++
 rtl/id_fwd_ctrl_if.sv | 22 ++
 rtl/id_fwd_ctrl_fwd_select.sv | 34 +++
 rtl/id_fwd_ctrl.sv | 111 +++++++++++
 tb/tb_id_fwd_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_fwd_ctrl_pkg.sv
// id_fwd_ctrl shared definitions
// stall encoding, IF/ID bundle, source bus width
package id_fwd_ctrl_pkg;

  localparam int STALL_W     = 6;
  localparam bit Stop        = 1'b1;
  localparam bit NoStop      = 1'b0;
  localparam int IF_TO_ID_WD = 33;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_id_t;

  function automatic int fwd_src_wd(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/id_fwd_ctrl_if.sv
// IF -> ID instruction bus
// master is the fetch side, slave is the decode front end
interface id_fwd_ctrl_if;

  logic        if_ce;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic        id_ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    output if_ce, if_pc, inst_sram_rdata,
    input  id_ce, id_pc, id_inst
  );

  modport slave (
    input  if_ce, if_pc, inst_sram_rdata,
    output id_ce, id_pc, id_inst
  );

endinterface

// File: rtl/id_fwd_ctrl_fwd_select.sv
// one read port's forwarding priority match
// lowest source index (youngest) wins; r0 never matches
module fwd_select #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3
) (
  input  logic [ADDR_W-1:0]      i_raddr,
  input  logic [DATA_W-1:0]      i_rf_rdata,
  input  logic [NSRC-1:0]        i_we,
  input  logic [NSRC*ADDR_W-1:0] i_waddr,
  input  logic [NSRC*DATA_W-1:0] i_wdata,
  input  logic [NSRC-1:0]        i_ready,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_hit,
  output logic                   o_ready
);

  // scan oldest to youngest so the youngest match overrides
  always_comb begin
    o_data  = i_rf_rdata;
    o_hit   = 1'b0;
    o_ready = 1'b1;
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (i_we[s] && (i_raddr != '0) &&
          (i_waddr[s*ADDR_W +: ADDR_W] == i_raddr)) begin
        o_data  = i_wdata[s*DATA_W +: DATA_W];
        o_hit   = 1'b1;
        o_ready = i_ready[s];
      end
    end
  end

endmodule

// File: rtl/id_fwd_ctrl.sv
// decode-stage front end: IF/ID register, stall hold
// buffer, operand forwarding, load-use interlock
module id_fwd_ctrl
  import id_fwd_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NSRC    = 3,
  parameter int NRD     = 2,
  parameter int STALL_W = id_fwd_ctrl_pkg::STALL_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [STALL_W-1:0]     i_stall,
  input  logic                   i_flush,
  id_fwd_ctrl_if.slave           bus,
  input  logic [NRD*ADDR_W-1:0]  i_raddr,
  input  logic [NRD-1:0]         i_rd_used,
  input  logic [NRD*DATA_W-1:0]  i_rf_rdata,
  input  logic [NSRC-1:0]        i_src_we,
  input  logic [NSRC*ADDR_W-1:0] i_src_waddr,
  input  logic [NSRC*DATA_W-1:0] i_src_wdata,
  input  logic [NSRC-1:0]        i_src_ready,
  output logic [NRD*DATA_W-1:0]  o_opnd,
  output logic                   o_stallreq,
  output logic [31:0]            o_stall_cnt
);

  if_id_t      r_ifid;
  logic        r_hold_vld;
  logic [31:0] r_hold_inst;
  logic [31:0] r_stall_cnt;

  logic        w_id_stop;
  logic        w_ex_stop;
  logic        w_bubble;
  logic        w_held;
  logic [NRD-1:0] w_hit;
  logic [NRD-1:0] w_rdy;
  logic        w_unused_stall;

  assign w_id_stop = (i_stall[1] == Stop);
  assign w_ex_stop = (i_stall[2] == Stop);
  assign w_bubble  = w_id_stop && !w_ex_stop;
  assign w_held    = w_id_stop && w_ex_stop;

  assign w_unused_stall = ^{i_stall[STALL_W-1:3], i_stall[0]};

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ifid <= '0;
    end else if (i_flush || w_bubble) begin
      r_ifid <= '0;
    end else if (!w_id_stop) begin
      r_ifid <= if_id_t'({bus.if_ce, bus.if_pc});
    end
  end

  // keep the SRAM word alive while ID is held
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold_vld  <= 1'b0;
      r_hold_inst <= '0;
    end else if (i_flush || w_bubble || !w_id_stop) begin
      r_hold_vld  <= 1'b0;
    end else if (w_held && !r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_hold_inst <= bus.inst_sram_rdata;
    end
  end

  assign bus.id_ce   = r_ifid.ce;
  assign bus.id_pc   = r_ifid.pc;
  assign bus.id_inst = !r_ifid.ce ? 32'h0 :
                       r_hold_vld ? r_hold_inst :
                       bus.inst_sram_rdata;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NSRC   (NSRC)
    ) u_sel (
      .i_raddr    (i_raddr[p*ADDR_W +: ADDR_W]),
      .i_rf_rdata (i_rf_rdata[p*DATA_W +: DATA_W]),
      .i_we       (i_src_we),
      .i_waddr    (i_src_waddr),
      .i_wdata    (i_src_wdata),
      .i_ready    (i_src_ready),
      .o_data     (o_opnd[p*DATA_W +: DATA_W]),
      .o_hit      (w_hit[p]),
      .o_ready    (w_rdy[p])
    );
  end

  assign o_stallreq = bus.id_ce &&
                      |(i_rd_used & w_hit & ~w_rdy);

  // saturating count of interlock cycles
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (o_stallreq && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_fwd_ctrl.sv
// id_fwd_ctrl testbench
// directed steps, expected values queued then popped
module tb_id_fwd_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 3;
  localparam int NRD    = 2;
  localparam int SW     = 6;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [SW-1:0]          stall;
  logic                   flush;
  logic [NRD*ADDR_W-1:0]  raddr;
  logic [NRD-1:0]         rd_used;
  logic [NRD*DATA_W-1:0]  rf_rdata;
  logic [NSRC-1:0]        src_we;
  logic [NSRC*ADDR_W-1:0] src_waddr;
  logic [NSRC*DATA_W-1:0] src_wdata;
  logic [NSRC-1:0]        src_ready;
  logic [NRD*DATA_W-1:0]  opnd;
  logic                   stallreq;
  logic [31:0]            stall_cnt;

  id_fwd_ctrl_if bus ();

  id_fwd_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NSRC (NSRC),
    .NRD (NRD), .STALL_W (SW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_stall     (stall),
    .i_flush     (flush),
    .bus         (bus.slave),
    .i_raddr     (raddr),
    .i_rd_used   (rd_used),
    .i_rf_rdata  (rf_rdata),
    .i_src_we    (src_we),
    .i_src_waddr (src_waddr),
    .i_src_wdata (src_wdata),
    .i_src_ready (src_ready),
    .o_opnd      (opnd),
    .o_stallreq  (stallreq),
    .o_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tot++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h",
                  e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic we,
                         input logic [4:0] a,
                         input logic [31:0] d,
                         input logic rdy);
    src_we[s]                  = we;
    src_waddr[s*ADDR_W +: ADDR_W] = a;
    src_wdata[s*DATA_W +: DATA_W] = d;
    src_ready[s]               = rdy;
  endtask

  initial begin
    resetn    = 1'b0;
    stall     = '0;
    flush     = 1'b0;
    raddr     = '0;
    rd_used   = '0;
    rf_rdata  = '0;
    src_we    = '0;
    src_waddr = '0;
    src_wdata = '0;
    src_ready = '1;
    bus.if_ce = 1'b1;
    bus.if_pc = 32'hBFC0_0000;
    bus.inst_sram_rdata = 32'hFFFF_FFFF;
    step(2);

    push("rst_id_ce", 32'd0);      chk({31'd0, bus.id_ce});
    push("rst_id_pc", 32'd0);      chk(bus.id_pc);
    push("rst_id_inst", 32'd0);    chk(bus.id_inst);
    push("rst_stall_cnt", 32'd0);  chk(stall_cnt);
    push("rst_stallreq", 32'd0);   chk({31'd0, stallreq});

    resetn = 1'b1;
    step();
    push("load_id_ce", 32'd1);     chk({31'd0, bus.id_ce});
    push("load_id_pc", 32'hBFC0_0000); chk(bus.id_pc);

    // forwarding priority
    rf_rdata[31:0] = 32'h99;
    raddr[4:0] = 5'd8;
    set_src(0, 1'b1, 5'd8, 32'h11, 1'b1);
    set_src(1, 1'b1, 5'd8, 32'h22, 1'b1);
    set_src(2, 1'b1, 5'd8, 32'h33, 1'b1);
    #1;
    push("fwd_ex", 32'h11);        chk(opnd[31:0]);
    src_we[0] = 1'b0; #1;
    push("fwd_mem", 32'h22);       chk(opnd[31:0]);
    src_we[1] = 1'b0; #1;
    push("fwd_wb", 32'h33);        chk(opnd[31:0]);
    src_we[2] = 1'b0; #1;
    push("fwd_none", 32'h99);      chk(opnd[31:0]);

    // load-use interlock
    set_src(0, 1'b1, 5'd9, 32'h44, 1'b0);
    raddr[9:5] = 5'd9;
    rd_used = 2'b10; #1;
    push("lu_used", 32'd1);        chk({31'd0, stallreq});
    rd_used = 2'b00; #1;
    push("lu_unused", 32'd0);      chk({31'd0, stallreq});
    set_src(2, 1'b1, 5'd9, 32'h55, 1'b1);
    rd_used = 2'b10; #1;
    push("lu_wb_nomask", 32'd1);   chk({31'd0, stallreq});
    push("lu_opnd_ex", 32'h44);    chk(opnd[63:32]);
    stall = 6'b000110; #1;
    push("lu_stall_indep", 32'd1); chk({31'd0, stallreq});
    stall = '0;
    src_we = '0;
    rd_used = '0; #1;

    // zero register
    set_src(0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    set_src(1, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    set_src(2, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    raddr[4:0] = 5'd0;
    rf_rdata[31:0] = 32'h0;
    rd_used = 2'b01; #1;
    push("r0_opnd", 32'h0);        chk(opnd[31:0]);
    push("r0_stallreq", 32'd0);    chk({31'd0, stallreq});
    src_we = '0;
    rd_used = '0;
    src_ready = '1; #1;

    // stall counter
    set_src(0, 1'b1, 5'd9, 32'h44, 1'b0);
    rd_used = 2'b10;
    step(5);
    src_we = '0; #1;
    push("cnt_5", 32'd5);          chk(stall_cnt);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    #1;
    src_we[0] = 1'b1;
    step(3);
    src_we = '0; #1;
    push("cnt_sat", 32'hFFFF_FFFF); chk(stall_cnt);
    resetn = 1'b0;
    step();
    push("cnt_rst", 32'd0);        chk(stall_cnt);
    resetn = 1'b1;
    rd_used = '0;

    // hold buffer
    bus.if_pc = 32'hBFC0_0004;
    step();
    bus.inst_sram_rdata = 32'h3C01_1234; #1;
    push("hold_latch", 32'h3C01_1234); chk(bus.id_inst);
    stall = 6'b000110;
    bus.if_pc = 32'hBFC0_0008;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.inst_sram_rdata = 32'hAAAA_0000 + i; #1;
      push("hold_keep", 32'h3C01_1234); chk(bus.id_inst);
    end
    push("hold_pc", 32'hBFC0_0004); chk(bus.id_pc);
    stall = '0;
    step();
    bus.inst_sram_rdata = 32'h5555_0000; #1;
    push("hold_release", 32'h5555_0000); chk(bus.id_inst);
    push("hold_rel_pc", 32'hBFC0_0008);  chk(bus.id_pc);

    // bubble
    stall = 6'b000010;
    step();
    push("bub_ce", 32'd0);         chk({31'd0, bus.id_ce});
    push("bub_pc", 32'd0);         chk(bus.id_pc);
    push("bub_inst", 32'd0);       chk(bus.id_inst);

    // flush
    stall = '0;
    bus.if_pc = 32'hBFC0_000C;
    step();
    push("pre_flush_ce", 32'd1);   chk({31'd0, bus.id_ce});
    flush = 1'b1;
    bus.if_pc = 32'hBFC0_0010;
    step();
    flush = 1'b0;
    push("flush_ce", 32'd0);       chk({31'd0, bus.id_ce});
    push("flush_pc", 32'd0);       chk(bus.id_pc);

    // reset during held stall drops the hold
    step();
    bus.inst_sram_rdata = 32'h1111_1111;
    stall = 6'b000110;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    stall = '0;
    step();
    bus.inst_sram_rdata = 32'h2222_2222; #1;
    push("rst_hold_drop", 32'h2222_2222); chk(bus.id_inst);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
